// File: rtl/in_cond_pkg.sv
// Shared constants and helpers for the ui_in input conditioner.
package in_cond_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // Counter must hold 0 .. cycles-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: synchroniser chain, persistence counter, stable level
// and single-cycle edge pulses.
module debounce_ch
  import in_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s != lvl) begin
        // Accept only after the new value has persisted long enough.
        if (cnt == CNT_LAST) begin
          lvl  <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Returning to the stable level discards any partial count.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_debounce2.sv
// Two-channel conditioner feeding C_AND: ui_in[1:0] in, clean a/b levels out.
module input_debounce2
  import in_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] raw_i,
  output logic       a_o,
  output logic       b_o,
  output logic [1:0] rise_o,
  output logic [1:0] fall_o
);

  logic [1:0] lvl;

  for (genvar k = 0; k < 2; k++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_i[k]),
      .lvl  (lvl[k]),
      .rise (rise_o[k]),
      .fall (fall_o[k])
    );
  end

  assign a_o = lvl[0];
  assign b_o = lvl[1];

endmodule
